// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // Fetch sequencer states: ISSUE sends a request, WAIT holds until the
  // word returns, DRAIN swallows the response of a squashed request.
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0 -- presented to decode whenever the queue is empty.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  // One queued instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order FIFO of fetched {pc, instr} pairs. Entry 0 is always
// the head, so the head is read straight out of a register.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t e0_q, e0_d;
  fetch_entry_t e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop;
  logic         do_push;

  // Next-state of the two slots and the occupancy count.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = push_data_i;
          else               e1_d = push_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            e0_d = push_data_i;
          end else begin
            e0_d = e1_q;
            e1_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Slot and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e0_q  <= '{pc: 32'd0, instr: NOP_INSTR};
      e1_q  <= '{pc: 32'd0, instr: NOP_INSTR};
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = e0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory
// read in flight, queues returned words and hands them to decode.
//
// Decode handshake: if_valid_o means the if_* head outputs hold a real
// instruction; the head is consumed on any rising edge where both
// if_valid_o and id_ready_i are high. The if_* outputs come only from
// registers, so id_ready_i never reaches them combinationally.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_rvalid_i,
  input  logic [31:0]  imem_rdata_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic         if_valid_o,
  input  logic         id_ready_i,
  output logic [31:0]  if_instr_o,
  output logic [6:0]   if_op_o,
  output logic [31:0]  if_pc_o,
  output logic [31:0]  if_pc_plus4_o,
  output fetch_state_e dbg_state_o
);

  localparam logic [1:0] FULL_COUNT = 2'(QUEUE_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  // Low during the cycle reset releases so the first request lands one
  // cycle later and the request line stays quiet while in reset.
  logic         run_q;
  logic         q_push;
  logic         q_pop;
  logic         q_flush;
  logic [1:0]   q_count;
  fetch_entry_t q_head;
  fetch_entry_t q_push_data;
  logic         req;

  // Sequencer next-state, PC update and request generation.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    q_push  = 1'b0;
    q_flush = 1'b0;
    req     = 1'b0;
    if (redirect_i) begin
      // A redirect beats every other event: squash, retarget, no request.
      pc_d    = word_align(redirect_pc_i);
      q_flush = 1'b1;
      unique case (state_q)
        ST_ISSUE: state_d = ST_ISSUE;
        ST_WAIT:  state_d = imem_rvalid_i ? ST_ISSUE : ST_DRAIN;
        ST_DRAIN: state_d = ST_DRAIN;
        default:  state_d = ST_ISSUE;
      endcase
    end else begin
      unique case (state_q)
        ST_ISSUE: begin
          if (run_q && (q_count < FULL_COUNT)) begin
            req     = 1'b1;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A slot was free when this request went out, so the push fits.
          if (imem_rvalid_i) begin
            q_push  = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid_i) state_d = ST_ISSUE;
        end
        default: state_d = ST_ISSUE;
      endcase
    end
  end

  // Sequencer state, PC and start-up registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ISSUE;
      pc_q    <= RESET_PC;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      run_q   <= 1'b1;
    end
  end

  assign q_push_data = '{pc: pc_q, instr: imem_rdata_i};
  assign q_pop       = if_valid_o && id_ready_i;

  fetch_queue u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (q_push),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .flush_i     (q_flush),
    .count_o     (q_count),
    .head_o      (q_head)
  );

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_q;
  assign if_valid_o    = (q_count != 2'd0);
  assign if_instr_o    = if_valid_o ? q_head.instr : NOP_INSTR;
  assign if_pc_o       = if_valid_o ? q_head.pc : 32'd0;
  assign if_op_o       = if_instr_o[6:0];
  assign if_pc_plus4_o = if_pc_o + 32'd4;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed vector table for the reset-release
// sequence, hand-written corner sequences, then randomized traffic checked
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0040_0000;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         imem_req_o;
  logic [31:0]  imem_addr_o;
  logic         imem_rvalid_i;
  logic [31:0]  imem_rdata_i;
  logic         redirect_i;
  logic [31:0]  redirect_pc_i;
  logic         if_valid_o;
  logic         id_ready_i;
  logic [31:0]  if_instr_o;
  logic [6:0]   if_op_o;
  logic [31:0]  if_pc_o;
  logic [31:0]  if_pc_plus4_o;
  fetch_state_e dbg_state;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_valid_o    (if_valid_o),
    .id_ready_i    (id_ready_i),
    .if_instr_o    (if_instr_o),
    .if_op_o       (if_op_o),
    .if_pc_o       (if_pc_o),
    .if_pc_plus4_o (if_pc_plus4_o),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int delivered = 0;

  logic [63:0] exp_q[$];      // {pc, instr} expected at decode, in order
  logic [31:0] req_log[$];    // addresses requested since last clear
  logic [31:0] exp_pc;        // address the next fetch must use
  bit          outst;         // a read is in flight
  bit          stale;         // ... and its data belongs to a squashed path
  bit          first;         // the cycle reset releases

  // memory model
  bit          mem_pending;
  int          mem_due;
  logic [31:0] mem_addr;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          cur_rv;
  bit          cur_stray;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RPC) return 32'h0050_0093;
    return {a[15:2], a[31:16], 2'b11} ^ 32'h1357_9BDC;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rdy, input bit redir, input logic [31:0] tgt, input bit stray);
    bit r;
    cyc++;
    r = redir;
    cur_stray = stray;
    cur_rv = mem_pending && (cyc == mem_due);
    if (cur_rv) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mem_addr);
      mem_pending   = 1'b0;
    end else if (stray) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      cur_rv        = 1'b1;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    // Decode never redirects again in the exact cycle a squashed read lands.
    if (r && outst && stale && cur_rv) r = 1'b0;
    redirect_i    = r;
    redirect_pc_i = tgt;
    id_ready_i    = rdy;
  endtask

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic check_update();
    bit          exp_req;
    logic [63:0] h;
    exp_req = !first && !outst && (exp_q.size() < 2) && !redirect_i;
    chk("imem_req", 32'(imem_req_o), 32'(exp_req));
    chk("imem_addr", imem_addr_o, exp_pc);
    chk("if_valid", 32'(if_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) h = exp_q[0];
    else                   h = {32'd0, NOP_INSTR};
    chk("if_instr", if_instr_o, h[31:0]);
    chk("if_pc", if_pc_o, h[63:32]);
    chk("if_pc_plus4", if_pc_plus4_o, h[63:32] + 32'd4);
    chk("if_op", 32'(if_op_o), 32'(h[6:0]));

    if (id_ready_i && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    if (redirect_i) begin
      exp_q.delete();
      exp_pc = {redirect_pc_i[31:2], 2'b00};
      if (outst) begin
        if (cur_rv && !cur_stray) outst = 1'b0;
        else                      stale = 1'b1;
      end
    end else if (cur_rv && !cur_stray && outst) begin
      if (!stale) begin
        exp_q.push_back({exp_pc, mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      outst = 1'b0;
      stale = 1'b0;
    end
    if (exp_req) begin
      outst = 1'b1;
      stale = 1'b0;
    end
    if (imem_req_o) begin
      mem_pending = 1'b1;
      mem_addr    = imem_addr_o;
      mem_due     = cyc + $urandom_range(lat_max, lat_min);
      req_log.push_back(imem_addr_o);
    end
    first = 1'b0;
  endtask

  task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    drive(rdy, redir, tgt, 1'b0);
    @(negedge clk);
    check_update();
  endtask

  task automatic check_reset_values();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, RPC);
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    chk("rst_instr", if_instr_o, NOP_INSTR);
    chk("rst_state", 32'(dbg_state), 32'(ST_ISSUE));
  endtask

  // Assert reset mid-cycle, release a cycle later, run the release cycle.
  task automatic do_reset(input bit stray);
    @(posedge clk);
    #1;
    reset = 1'b0;
    redirect_i = 1'b0;
    imem_rvalid_i = 1'b0;
    id_ready_i = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    req_log.delete();
    outst = 1'b0;
    stale = 1'b0;
    first = 1'b1;
    exp_pc = RPC;
    mem_pending = 1'b0;
    drive(1'b1, 1'b0, 32'd0, stray);
    @(negedge clk);
    check_update();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rv;
    logic [31:0] rdata;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    reset = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'd0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'd0;
    id_ready_i = 1'b0;
    #2;
    reset = 1'b0;

    // Reset release with a 1-cycle memory; row index = cycles after release.
    tbl[0] = '{1'b0, 32'd0,         1'b1, 1'b0, RPC,            1'b0, NOP_INSTR,    32'd0};
    tbl[1] = '{1'b0, 32'd0,         1'b1, 1'b1, RPC,            1'b0, NOP_INSTR,    32'd0};
    tbl[2] = '{1'b1, 32'h0050_0093, 1'b1, 1'b0, RPC,            1'b0, NOP_INSTR,    32'd0};
    tbl[3] = '{1'b0, 32'd0,         1'b1, 1'b1, RPC + 32'd4,    1'b1, 32'h0050_0093, RPC};
    tbl[4] = '{1'b1, 32'h00a0_0113, 1'b1, 1'b0, RPC + 32'd4,    1'b0, NOP_INSTR,    32'd0};
    tbl[5] = '{1'b0, 32'd0,         1'b0, 1'b1, RPC + 32'd8,    1'b1, 32'h00a0_0113, RPC + 32'd4};

    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      imem_rvalid_i = tbl[i].rv;
      imem_rdata_i  = tbl[i].rdata;
      id_ready_i    = tbl[i].rdy;
      @(negedge clk);
      chk("tbl_req", 32'(imem_req_o), 32'(tbl[i].e_req));
      chk("tbl_addr", imem_addr_o, tbl[i].e_addr);
      chk("tbl_valid", 32'(if_valid_o), 32'(tbl[i].e_valid));
      chk("tbl_instr", if_instr_o, tbl[i].e_instr);
      chk("tbl_pc", if_pc_o, tbl[i].e_pc);
      chk("tbl_pc_plus4", if_pc_plus4_o, tbl[i].e_pc + 32'd4);
      chk("tbl_op", 32'(if_op_o), 32'(tbl[i].e_instr & 32'h7F));
    end

    // Decode stalled for 10 cycles: two fetches fill the queue, then stop.
    lat_min = 1; lat_max = 1;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0);
    chk("stall_req_count", 32'(req_log.size()), 32'd2);
    if (req_log.size() >= 2) begin
      chk("stall_req0", req_log[0], RPC);
      chk("stall_req1", req_log[1], RPC + 32'd4);
    end
    chk("stall_full_valid", 32'(if_valid_o), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0);
    chk("resume_req_count", 32'(req_log.size() > 2), 32'd1);
    if (req_log.size() > 2) chk("resume_req2", req_log[2], RPC + 32'd8);

    // Redirect while waiting; the late response must be dropped via DRAIN.
    lat_min = 4; lat_max = 4;
    do_reset(1'b0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h0040_0103);
    req_log.delete();
    step(1'b1, 1'b0, 32'd0);
    chk("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
    chk("drain_req_count", 32'(req_log.size()), 32'd1);
    if (req_log.size() >= 1) chk("drain_req_addr", req_log[0], 32'h0040_0100);

    // Redirect in the same cycle as the response: no DRAIN, refetch next cycle.
    lat_min = 2; lat_max = 2;
    do_reset(1'b0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h0040_0200);
    req_log.delete();
    step(1'b1, 1'b0, 32'd0);
    chk("same_cycle_state", 32'(dbg_state), 32'(ST_ISSUE));
    chk("same_cycle_req_count", 32'(req_log.size()), 32'd1);
    if (req_log.size() >= 1) chk("same_cycle_req_addr", req_log[0], 32'h0040_0200);

    // Reset while a read is pending, with a stray response after release.
    lat_min = 5; lat_max = 5;
    do_reset(1'b0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    lat_min = 1; lat_max = 1;
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0);
    chk("post_reset_req_count", 32'(req_log.size() >= 1), 32'd1);
    if (req_log.size() >= 1) chk("post_reset_req_addr", req_log[0], RPC);

    // Redirect near the top of the address space: PC wraps to zero.
    do_reset(1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    req_log.delete();
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("wrap_req_count", 32'(req_log.size()), 32'd2);
    if (req_log.size() >= 2) begin
      chk("wrap_req0", req_log[0], 32'hFFFF_FFFC);
      chk("wrap_req1", req_log[1], 32'h0000_0000);
    end
    chk("wrap_head_pc", if_pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", if_pc_plus4_o, 32'h0000_0000);

    // Randomized traffic against the model.
    lat_min = 1; lat_max = 3;
    do_reset(1'b0);
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
    end
    chk("random_progress", 32'(delivered > 200), 32'd1);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
